// File: rtl/display7_scan.sv
// Multiplexed N-digit hex 7-segment scanner with shadow register and registered outputs.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module display7_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [4*NUM_DIGITS-1:0] iData,
    input  logic                    iLoad,
    input  logic                    iBlank,
    output logic [NUM_DIGITS-1:0]   oSel,
    output logic [6:0]              oSeg,
    output logic                    oFrame
);

    localparam int              IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    frame_q, frame_d;
    logic                    tick;
    logic [3:0]              nib;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        case (n)
            4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h10;
            4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;  4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;  default: hex2seg = 7'h0E;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_above;

    // Walk from the top digit down; a digit is dark while everything at/above it is zero.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above  = zero_above && (shadow_q[4*k +: 4] == 4'h0);
            lz_blank[k] = (k != 0) && zero_above;
        end
    end
`endif

    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        shadow_d = iLoad ? iData : shadow_q;
        frame_d  = tick && (idx_q == IDX_MAX);

        nib   = shadow_q[{idx_q, 2'b00} +: 4];
        sel_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) sel_d[k] = (idx_q != IDX_W'(k));
        seg_d = hex2seg(nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (lz_blank[idx_q]) seg_d = 7'h7F;
`endif
        // Blank only masks the pins; the scan keeps running underneath.
        if (iBlank) begin
            sel_d = '1;
            seg_d = 7'h7F;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            sel_q    <= '1;
            seg_q    <= 7'h7F;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign oSel   = sel_q;
    assign oSeg   = seg_q;
    assign oFrame = frame_q;

endmodule
